// File: rtl/fifo_burst_rd.sv
// Burst reader for the CDC FIFO consumer port: waits for BURST_LEN buffered words, then drains them
// through a registered valid/ready stage with sop/eop framing. Define FIFO_BURST_RD_TIMEOUT_EN for partial-burst flush.
module fifo_burst_rd #(
  parameter int DAT_BITS    = 8,
  parameter int ABITS       = 2,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_val,
  input  logic [DAT_BITS-1:0] i_dat,
  output logic                o_rdy,
  input  logic                i_emp,
  input  logic [ABITS:0]      i_wrds,
  output logic                o_val,
  output logic [DAT_BITS-1:0] o_dat,
  output logic                o_sop,
  output logic                o_eop,
  input  logic                i_rdy,
  output logic                o_busy,
  output logic [15:0]         o_bursts
);

  if (BURST_LEN < 1 || BURST_LEN > (1 << ABITS) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("fifo_burst_rd: illegal parameter value");
  end

  // Handshakes: a word moves on either port only in a cycle where its valid and ready are both high;
  // o_val/o_dat/o_sop/o_eop never change while o_val=1 and i_rdy=0.
  typedef enum logic {S_IDLE, S_BURST} state_e;

  localparam logic [ABITS:0] BL = (ABITS+1)'(BURST_LEN);

  state_e              state_q, state_d;
  logic [ABITS:0]      rem_q, rem_d;
  logic                first_q, first_d;
  logic                val_q, val_d;
  logic [DAT_BITS-1:0] dat_q, dat_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [15:0]         bursts_q, bursts_d;
  logic [ABITS:0]      cnt;
  logic                pop;

`ifdef FIFO_BURST_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  // The FIFO reports a full-looking count while empty, so the flag always wins.
  assign cnt   = i_emp ? '0 : i_wrds;
  assign o_rdy = (state_q == S_BURST) & (~val_q | i_rdy) & ~i_rst;
  assign pop   = i_val & o_rdy;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    first_d  = first_q;
    val_d    = val_q;
    dat_d    = dat_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    bursts_d = bursts_q;
    case (state_q)
      S_IDLE: begin
        if (cnt >= BL) begin
          state_d = S_BURST;
          rem_d   = BL;
          first_d = 1'b1;
        end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        else if (cnt != '0 && timer_q == TMAX) begin
          state_d = S_BURST;
          rem_d   = cnt;
          first_d = 1'b1;
        end
`endif
      end
      S_BURST: begin
        if (pop) begin
          first_d = 1'b0;
          rem_d   = rem_q - (ABITS+1)'(1);
          if (rem_q == (ABITS+1)'(1)) begin
            state_d  = S_IDLE;
            bursts_d = bursts_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      val_d = 1'b1;
      dat_d = i_dat;
      sop_d = first_q;
      eop_d = (rem_q == (ABITS+1)'(1));
    end else if (val_q && i_rdy) begin
      val_d = 1'b0;
    end
  end

`ifdef FIFO_BURST_RD_TIMEOUT_EN
  always_comb begin
    timer_d = '0;
    if (state_q == S_IDLE && state_d == S_IDLE && cnt != '0 && cnt < BL)
      timer_d = timer_q + TW'(1);
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      first_q  <= 1'b0;
      val_q    <= 1'b0;
      dat_q    <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      bursts_q <= '0;
`ifdef FIFO_BURST_RD_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      val_q    <= val_d;
      dat_q    <= dat_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      bursts_q <= bursts_d;
`ifdef FIFO_BURST_RD_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign o_val    = val_q;
  assign o_dat    = dat_q;
  assign o_sop    = sop_q;
  assign o_eop    = eop_q;
  assign o_busy   = (state_q == S_BURST);
  assign o_bursts = bursts_q;

endmodule
